// File: rtl/freq_meas_seq_if.sv
// Host-side request/result bundle of the frequency measurement sequencer.
// The host drives requests and control; the sequencer returns status and results.
interface freq_meas_seq_if;
  logic        req_i;
  logic        cont_i;
  logic        abort_i;
  logic        busy;
  logic        res_valid;
  logic [11:0] result;
  logic        err;

  modport master (
    output req_i, cont_i, abort_i,
    input  busy, res_valid, result, err
  );

  modport slave (
    input  req_i, cont_i, abort_i,
    output busy, res_valid, result, err
  );
endinterface

// File: rtl/freq_meas_seq.sv
// Measurement sequencer: clears, runs and samples a frequency-to-digital converter.
// Optional averaging of 2**AVG_LOG2 conversions is enabled by defining FTD_AVG_EN.
module freq_meas_seq #(
  parameter int CLR_CYCLES  = 4,
  parameter int TIMEOUT     = 65535,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 2,
  parameter int AVG_LOG2    = 2
) (
  input  logic           clk,
  input  logic           rst,
  freq_meas_seq_if.slave host,
  output logic           meas_start,
  input  logic           meas_done,
  input  logic [11:0]    meas_data
);

  if (CLR_CYCLES < 1 || SYNC_STAGES < 2 || SETTLE < 1 || TIMEOUT < 1 || AVG_LOG2 < 0) begin : g_bad_params
    $error("freq_meas_seq: illegal parameter value");
  end

  localparam logic [15:0] CLR_LAST    = 16'(CLR_CYCLES - 1);
  localparam logic [15:0] TO_LAST     = 16'(TIMEOUT - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_SETTLE,
    ST_CAPTURE
  } state_t;

  state_t                   state;
  logic [15:0]              cnt;
  logic [SYNC_STAGES-1:0]   sync;
  logic                     done_s;

`ifdef FTD_AVG_EN
  localparam int ACC_W = 12 + AVG_LOG2;
  localparam logic [AVG_LOG2:0] LAST_SAMPLE = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [AVG_LOG2:0] nsamp;

  assign acc_sum = acc + ACC_W'(meas_data);
`endif

  // meas_done is asynchronous; the chain is held clear while the converter is held in clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else if (!meas_start) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], meas_done};
    end
  end

  assign done_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      meas_start     <= 1'b0;
      host.busy      <= 1'b0;
      host.res_valid <= 1'b0;
      host.result    <= '0;
      host.err       <= 1'b0;
`ifdef FTD_AVG_EN
      acc            <= '0;
      nsamp          <= '0;
`endif
    end else begin
      host.res_valid <= 1'b0;
      if (host.abort_i) begin
        state      <= ST_IDLE;
        cnt        <= '0;
        meas_start <= 1'b0;
        host.busy  <= 1'b0;
`ifdef FTD_AVG_EN
        acc        <= '0;
        nsamp      <= '0;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            if (host.req_i) begin
              state     <= ST_CLEAR;
              cnt       <= '0;
              host.busy <= 1'b1;
              host.err  <= 1'b0;
`ifdef FTD_AVG_EN
              acc       <= '0;
              nsamp     <= '0;
`endif
            end
          end
          ST_CLEAR: begin
            if (cnt == CLR_LAST) begin
              state      <= ST_RUN;
              cnt        <= '0;
              meas_start <= 1'b1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          // A done seen on the last allowed cycle still counts as a valid conversion
          ST_RUN: begin
            if (done_s) begin
              state <= ST_SETTLE;
              cnt   <= '0;
            end else if (cnt == TO_LAST) begin
              state      <= ST_IDLE;
              cnt        <= '0;
              meas_start <= 1'b0;
              host.busy  <= 1'b0;
              host.err   <= 1'b1;
`ifdef FTD_AVG_EN
              acc        <= '0;
              nsamp      <= '0;
`endif
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          ST_SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              state <= ST_CAPTURE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          // meas_start stays high through CAPTURE so meas_data is still frozen when sampled
          ST_CAPTURE: begin
            cnt        <= '0;
            meas_start <= 1'b0;
`ifdef FTD_AVG_EN
            if (nsamp == LAST_SAMPLE) begin
              host.result    <= acc_sum[ACC_W-1:AVG_LOG2];
              host.res_valid <= 1'b1;
              acc            <= '0;
              nsamp          <= '0;
              state          <= host.cont_i ? ST_CLEAR : ST_IDLE;
              host.busy      <= host.cont_i;
            end else begin
              acc   <= acc_sum;
              nsamp <= nsamp + 1'b1;
              state <= ST_CLEAR;
            end
`else
            host.result    <= meas_data;
            host.res_valid <= 1'b1;
            state          <= host.cont_i ? ST_CLEAR : ST_IDLE;
            host.busy      <= host.cont_i;
`endif
          end
          default: begin
            state      <= ST_IDLE;
            cnt        <= '0;
            meas_start <= 1'b0;
            host.busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_meas_seq.sv
// Self-checking bench for freq_meas_seq with a behavioural converter and result model.
// Expectations follow FTD_AVG_EN the same way the design does.
module tb_freq_meas_seq;
  localparam int CLR_CYCLES  = 4;
  localparam int TIMEOUT     = 1000;
  localparam int SYNC_STAGES = 2;
  localparam int SETTLE      = 2;
  localparam int AVG_LOG2    = 2;
`ifdef FTD_AVG_EN
  localparam int SAMPLES = 1 << AVG_LOG2;
`else
  localparam int SAMPLES = 1;
`endif

  logic        clk;
  logic        rst;
  logic        meas_start;
  logic        meas_done;
  logic [11:0] meas_data;

  int          checks;
  int          passes;
  int          pulse_count;
  int          model_n;
  int          conv_cnt;
  logic        prev_start;
  logic [11:0] data_q[$];
  logic [11:0] last_exp;

  freq_meas_seq_if host ();

  freq_meas_seq #(
    .CLR_CYCLES (CLR_CYCLES),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC_STAGES),
    .SETTLE     (SETTLE),
    .AVG_LOG2   (AVG_LOG2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (host),
    .meas_start(meas_start),
    .meas_done (meas_done),
    .meas_data (meas_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Converter model: new data per conversion, done rises model_n clocks after meas_start=1
  always @(posedge clk) begin
    #1;
    if (meas_start !== 1'b1) begin
      conv_cnt  = 0;
      meas_done = 1'b0;
    end else begin
      if (prev_start !== 1'b1 && data_q.size() > 0) meas_data = data_q.pop_front();
      conv_cnt++;
      if (model_n != 0 && conv_cnt >= model_n) meas_done = 1'b1;
    end
    prev_start = meas_start;
  end

  always @(posedge clk) begin
    #2;
    if (host.res_valid === 1'b1) pulse_count++;
  end

  function automatic logic [11:0] model_mean(input logic [11:0] v[$], input int first);
    int sum;
    sum = 0;
    for (int i = 0; i < SAMPLES; i++) sum += int'(v[first + i]);
    return 12'(sum / SAMPLES);
  endfunction

  task automatic pulse_req();
    @(negedge clk) host.req_i = 1'b1;
    @(negedge clk) host.req_i = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk) host.abort_i = 1'b1;
    @(negedge clk) host.abort_i = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (host.res_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    host.req_i = 1'b0; host.cont_i = 1'b0; host.abort_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (meas_start !== 1'b0) $display("[TB] FAIL reset_meas_start got %b want 0", meas_start); else passes++;
    checks++; if (host.busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", host.busy); else passes++;
    checks++; if (host.result !== 12'h000) $display("[TB] FAIL reset_result got %h want 000", host.result); else passes++;
    checks++; if (host.err !== 1'b0) $display("[TB] FAIL reset_err got %b want 0", host.err); else passes++;
    checks++; if (host.res_valid !== 1'b0) $display("[TB] FAIL reset_res_valid got %b want 0", host.res_valid); else passes++;
    last_exp = 12'h000;
  endtask

  task automatic test_single(input logic [11:0] data, input int n);
    logic [11:0] exp;
    int lat, base;
    bit got;
    data_q.delete();
    for (int i = 0; i < SAMPLES; i++) data_q.push_back(data);
    exp = model_mean(data_q, 0);
    model_n = n;
    base = pulse_count;
    @(negedge clk) host.req_i = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      host.req_i = 1'b0;
      lat++;
      if (lat == 1) begin
        checks++; if (host.busy !== 1'b1) $display("[TB] FAIL single_busy_rise got %b want 1", host.busy); else passes++;
      end
      if (meas_start === 1'b1) break;
    end
    checks++; if (lat != CLR_CYCLES + 1) $display("[TB] FAIL single_start_latency got %0d want %0d", lat, CLR_CYCLES + 1); else passes++;
    wait_valid(SAMPLES * (n + 40) + 100, got);
    checks++; if (!got) $display("[TB] FAIL single_res_valid got none want pulse"); else passes++;
    checks++; if (host.result !== exp) $display("[TB] FAIL single_result got %h want %h", host.result, exp); else passes++;
    last_exp = exp;
    @(negedge clk);
    checks++; if (host.res_valid !== 1'b0) $display("[TB] FAIL single_pulse_width got %b want 0", host.res_valid); else passes++;
    checks++; if (host.busy !== 1'b0) $display("[TB] FAIL single_busy_fall got %b want 0", host.busy); else passes++;
    checks++; if (pulse_count - base != 1) $display("[TB] FAIL single_pulse_count got %0d want 1", pulse_count - base); else passes++;
  endtask

  task automatic test_continuous(input logic [11:0] vals[$], input int n);
    logic [11:0] exp[$];
    int nres, base, gap;
    bit got;
    nres = vals.size() / SAMPLES;
    for (int r = 0; r < nres; r++) exp.push_back(model_mean(vals, r * SAMPLES));
    data_q = vals;
    model_n = n;
    base = pulse_count;
    host.cont_i = 1'b1;
    pulse_req();
    for (int r = 0; r < nres; r++) begin
      if (r == nres - 1) host.cont_i = 1'b0;
      wait_valid(SAMPLES * (n + 40) + 100, got);
      checks++; if (!got) $display("[TB] FAIL cont_res_valid[%0d] got none want pulse", r); else passes++;
      checks++; if (host.result !== exp[r]) $display("[TB] FAIL cont_result[%0d] got %h want %h", r, host.result, exp[r]); else passes++;
      last_exp = exp[r];
      if (r < nres - 1) begin
        gap = 0;
        while (meas_start !== 1'b1 && gap < 20) begin
          gap++;
          @(negedge clk);
        end
        checks++; if (gap != CLR_CYCLES) $display("[TB] FAIL cont_clear_gap[%0d] got %0d want %0d", r, gap, CLR_CYCLES); else passes++;
      end
    end
    @(negedge clk);
    checks++; if (host.busy !== 1'b0) $display("[TB] FAIL cont_busy_end got %b want 0", host.busy); else passes++;
    checks++; if (pulse_count - base != nres) $display("[TB] FAIL cont_pulse_count got %0d want %0d", pulse_count - base, nres); else passes++;
  endtask

  task automatic test_timeout();
    int run, base;
    data_q.delete();
    model_n = 0;
    base = pulse_count;
    pulse_req();
    for (int i = 0; i < 20 && meas_start !== 1'b1; i++) @(negedge clk);
    run = 0;
    while (meas_start === 1'b1 && run < TIMEOUT + 50) begin
      run++;
      @(negedge clk);
    end
    checks++; if (run != TIMEOUT) $display("[TB] FAIL timeout_run_cycles got %0d want %0d", run, TIMEOUT); else passes++;
    checks++; if (host.err !== 1'b1) $display("[TB] FAIL timeout_err got %b want 1", host.err); else passes++;
    checks++; if (host.busy !== 1'b0) $display("[TB] FAIL timeout_busy got %b want 0", host.busy); else passes++;
    checks++; if (pulse_count != base) $display("[TB] FAIL timeout_no_valid got %0d pulses want 0", pulse_count - base); else passes++;
    checks++; if (host.result !== last_exp) $display("[TB] FAIL timeout_result_held got %h want %h", host.result, last_exp); else passes++;
    pulse_abort();
    checks++; if (host.err !== 1'b1) $display("[TB] FAIL abort_keeps_err got %b want 1", host.err); else passes++;
    pulse_req();
    checks++; if (host.err !== 1'b0) $display("[TB] FAIL req_clears_err got %b want 0", host.err); else passes++;
    pulse_abort();
    checks++; if (host.busy !== 1'b0) $display("[TB] FAIL abort_clear_busy got %b want 0", host.busy); else passes++;
  endtask

  task automatic test_abort_done();
    int base;
    data_q.delete();
    for (int i = 0; i < SAMPLES; i++) data_q.push_back(12'($urandom));
    model_n = $urandom_range(10, 30);
    base = pulse_count;
    pulse_req();
    for (int i = 0; i < 200 && meas_done !== 1'b1; i++) @(negedge clk);
    checks++; if (meas_done !== 1'b1) $display("[TB] FAIL abort_done_seen got %b want 1", meas_done); else passes++;
    repeat (SYNC_STAGES) @(posedge clk);
    @(negedge clk) host.abort_i = 1'b1;
    @(negedge clk) host.abort_i = 1'b0;
    repeat (SETTLE + 10) @(negedge clk);
    checks++; if (pulse_count != base) $display("[TB] FAIL abort_no_valid got %0d pulses want 0", pulse_count - base); else passes++;
    checks++; if (host.busy !== 1'b0) $display("[TB] FAIL abort_busy got %b want 0", host.busy); else passes++;
    checks++; if (meas_start !== 1'b0) $display("[TB] FAIL abort_meas_start got %b want 0", meas_start); else passes++;
    checks++; if (host.result !== last_exp) $display("[TB] FAIL abort_result_held got %h want %h", host.result, last_exp); else passes++;
  endtask

`ifdef FTD_AVG_EN
  task automatic test_avg_abort();
    int base, falls;
    logic prev;
    logic [11:0] fresh[$];
    data_q.delete();
    for (int i = 0; i < SAMPLES; i++) data_q.push_back(12'hFFF);
    model_n = $urandom_range(8, 20);
    base = pulse_count;
    pulse_req();
    falls = 0;
    prev = meas_start;
    for (int i = 0; i < 400 && falls < 2; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && meas_start === 1'b0) falls++;
      prev = meas_start;
    end
    pulse_abort();
    checks++; if (pulse_count != base) $display("[TB] FAIL avg_abort_no_valid got %0d pulses want 0", pulse_count - base); else passes++;
    checks++; if (host.busy !== 1'b0) $display("[TB] FAIL avg_abort_busy got %b want 0", host.busy); else passes++;
    for (int i = 0; i < SAMPLES; i++) fresh.push_back(12'($urandom_range(0, 255)));
    test_continuous(fresh, $urandom_range(8, 20));
  endtask
`endif

  task automatic test_random();
    logic [11:0] vals[$];
    int nres;
    for (int it = 0; it < 3; it++) begin
      vals.delete();
      nres = $urandom_range(1, 3);
      for (int i = 0; i < nres * SAMPLES; i++) vals.push_back(12'($urandom));
      test_continuous(vals, $urandom_range(5, 60));
    end
  endtask

  task automatic test_async_reset();
    data_q.delete();
    data_q.push_back(12'h3C3);
    model_n = 200;
    pulse_req();
    for (int i = 0; i < 20 && meas_start !== 1'b1; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (meas_start !== 1'b0) $display("[TB] FAIL async_rst_meas_start got %b want 0", meas_start); else passes++;
    checks++; if (host.busy !== 1'b0) $display("[TB] FAIL async_rst_busy got %b want 0", host.busy); else passes++;
    checks++; if (host.result !== 12'h000) $display("[TB] FAIL async_rst_result got %h want 000", host.result); else passes++;
    @(negedge clk) rst = 1'b0;
    last_exp = 12'h000;
  endtask

  initial begin
    logic [11:0] spec_vals[$];
    checks = 0; passes = 0; pulse_count = 0; model_n = 0;
    conv_cnt = 0; prev_start = 1'b0; meas_done = 1'b0; meas_data = 12'h000;
    host.req_i = 1'b0; host.cont_i = 1'b0; host.abort_i = 1'b0;
    test_reset();
    test_single(12'h5A3, 300);
    spec_vals.delete();
    for (int i = 0; i < SAMPLES; i++) spec_vals.push_back(12'd100);
    for (int i = 0; i < SAMPLES; i++) spec_vals.push_back(12'd200);
    for (int i = 0; i < SAMPLES; i++) spec_vals.push_back(12'd300);
    test_continuous(spec_vals, 40);
    test_timeout();
    test_abort_done();
`ifdef FTD_AVG_EN
    spec_vals.delete();
    spec_vals.push_back(12'd10); spec_vals.push_back(12'd11);
    spec_vals.push_back(12'd12); spec_vals.push_back(12'd14);
    test_continuous(spec_vals, 25);
    test_avg_abort();
`endif
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
